// File: rtl/spi_slave_responder.sv
// spi_slave_responder: SPI mode-0 slave with synchronized inputs, a one-byte TX holding buffer and RX byte strobe.
// The SPI pins pass through a flop synchronizer and then a registered edge pulse.
module spi_slave_responder #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
   input  logic       clk_clk,
   input  logic       reset_reset_n,
   input  logic       spi_sclk,
   input  logic       spi_mosi,
   input  logic       spi_ss_n,
   output logic       spi_miso,
   output logic       spi_miso_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       tx_underrun,
   output logic       busy
);
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, mosi_sync_q, mosi_sync_d, ss_sync_q, ss_sync_d;
   logic sclk_prev_q, sclk_prev_d, ss_prev_q, ss_prev_d, mosi_dly_q, mosi_dly_d;
   logic sclk_rise_q, sclk_rise_d, sclk_fall_q, sclk_fall_d, ss_fall_q, ss_fall_d, ss_rise_q, ss_rise_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d, buf_q, buf_d, rx_data_q, rx_data_d;
   logic buf_full_q, buf_full_d, miso_q, miso_d, oe_q, oe_d;
   logic rx_valid_q, rx_valid_d, underrun_q, underrun_d;
   logic wr, load, upd_miso;

   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
      sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
      ss_prev_d   = ss_sync_q[SYNC_STAGES-1];
      // MOSI is delayed one stage so it lines up with the registered SCLK rise pulse
      mosi_dly_d  = mosi_sync_q[SYNC_STAGES-1];
      sclk_rise_d = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
      sclk_fall_d = ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
      ss_fall_d   = ~ss_sync_q[SYNC_STAGES-1] & ss_prev_q;
      ss_rise_d   = ss_sync_q[SYNC_STAGES-1] & ~ss_prev_q;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rx_sr_d    = rx_sr_q;
      tx_sr_d    = tx_sr_q;
      rx_data_d  = rx_data_q;
      miso_d     = miso_q;
      oe_d       = oe_q;
      rx_valid_d = 1'b0;
      underrun_d = 1'b0;
      load       = 1'b0;
      upd_miso   = 1'b0;
      wr         = tx_valid & ~buf_full_q;
      buf_d      = wr ? tx_data : buf_q;
      if (state_q == IDLE) begin
         if (ss_fall_q) begin
            state_d  = ACTIVE;
            cnt_d    = 3'd0;
            oe_d     = 1'b1;
            load     = 1'b1;
            upd_miso = 1'b1;
         end
      end else if (ss_rise_q) begin
         state_d = IDLE;
         cnt_d   = 3'd0;
         oe_d    = 1'b0;
         miso_d  = 1'b0;
      end else begin
         if (sclk_rise_q) begin
            rx_sr_d = {rx_sr_q[6:0], mosi_dly_q};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               rx_data_d  = rx_sr_d;
               rx_valid_d = 1'b1;
            end
         end
         if (sclk_fall_q) begin
            tx_sr_d  = {tx_sr_q[6:0], 1'b0};
            load     = cnt_q == 3'd0;
            upd_miso = 1'b1;
         end
      end
      // An empty buffer at load time sends IDLE_BYTE; a same-cycle write stays buffered
      if (load) begin
         tx_sr_d    = buf_full_q ? buf_q : IDLE_BYTE;
         underrun_d = ~buf_full_q;
      end
      buf_full_d = wr | (buf_full_q & ~load);
      if (upd_miso) miso_d = tx_sr_d[7];
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         ss_sync_q   <= '1;
         sclk_prev_q <= 1'b0;
         ss_prev_q   <= 1'b1;
         mosi_dly_q  <= 1'b0;
         sclk_rise_q <= 1'b0;
         sclk_fall_q <= 1'b0;
         ss_fall_q   <= 1'b0;
         ss_rise_q   <= 1'b0;
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         rx_sr_q     <= 8'h00;
         tx_sr_q     <= 8'h00;
         buf_q       <= 8'h00;
         buf_full_q  <= 1'b0;
         rx_data_q   <= 8'h00;
         miso_q      <= 1'b0;
         oe_q        <= 1'b0;
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         mosi_sync_q <= mosi_sync_d;
         ss_sync_q   <= ss_sync_d;
         sclk_prev_q <= sclk_prev_d;
         ss_prev_q   <= ss_prev_d;
         mosi_dly_q  <= mosi_dly_d;
         sclk_rise_q <= sclk_rise_d;
         sclk_fall_q <= sclk_fall_d;
         ss_fall_q   <= ss_fall_d;
         ss_rise_q   <= ss_rise_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rx_sr_q     <= rx_sr_d;
         tx_sr_q     <= tx_sr_d;
         buf_q       <= buf_d;
         buf_full_q  <= buf_full_d;
         rx_data_q   <= rx_data_d;
         miso_q      <= miso_d;
         oe_q        <= oe_d;
         rx_valid_q  <= rx_valid_d;
         underrun_q  <= underrun_d;
      end
   end

   assign spi_miso    = miso_q;
   assign spi_miso_oe = oe_q;
   assign tx_ready    = ~buf_full_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign tx_underrun = underrun_q;
   assign busy        = state_q == ACTIVE;
endmodule

// File: doc/spi_slave_responder.md
SPI_SLAVE_RESPONDER -- requirements
Module: spi_slave_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flip-flop synchronizer stages on spi_sclk, spi_mosi and spi_ss_n; legal values 2 or 3.
REQ-002 Parameter IDLE_BYTE, default 8'hFF: byte shifted out when no TX byte is buffered at byte start.
REQ-003 Port clk_clk, input, 1: system clock; all logic is clocked on its rising edge.
REQ-004 Port reset_reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port spi_sclk, input, 1: SPI clock from the master, asynchronous to clk_clk.
REQ-006 Port spi_mosi, input, 1: master-out data, asynchronous to clk_clk.
REQ-007 Port spi_ss_n, input, 1: active-low slave select, asynchronous to clk_clk.
REQ-008 Port spi_miso, output, 1: slave-out data.
REQ-009 Port spi_miso_oe, output, 1: MISO output enable; the top level uses it to tristate the pad.
REQ-010 Port tx_data, input, 8: next byte to transmit.
REQ-011 Port tx_valid, input, 1: tx_data is valid.
REQ-012 Port tx_ready, output, 1: the TX holding buffer is empty.
REQ-013 Port rx_data, output, 8: last complete byte received.
REQ-014 Port rx_valid, output, 1: one-cycle pulse; rx_data has been updated.
REQ-015 Port tx_underrun, output, 1: one-cycle pulse; IDLE_BYTE was loaded because the buffer was empty.
REQ-016 Port busy, output, 1: high while in state ACTIVE.

Function
REQ-017 Mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames; consecutive bytes are allowed within one SS_n assertion.
REQ-018 spi_sclk, spi_mosi and spi_ss_n shall each pass through SYNC_STAGES flops, then one edge-detect register; edges are detected on synchronized signals only.
REQ-019 Supported master timing: SCLK high and low phases each at least 4 clk_clk periods; SS_n fall to first SCLK rise at least 4 clk_clk periods.
REQ-020 States: IDLE and ACTIVE. IDLE->ACTIVE on a detected SS_n fall; ACTIVE->IDLE on a detected SS_n rise.
REQ-021 On IDLE->ACTIVE: bit counter=0; load the TX shift register (per REQ-024); spi_miso=shift[7]; spi_miso_oe=1.
REQ-022 In ACTIVE, on a detected SCLK rise: shift the synchronized MOSI into the RX shift register LSB; bit counter increments modulo 8.
REQ-023 Bit counter wrap 7->0: rx_data <= completed byte, and rx_valid pulses in the same cycle the update becomes visible.
  - Latency: rx_valid is high exactly SYNC_STAGES+1 clk_clk cycles after the clock edge that first samples the 8th raw SCLK high.
REQ-024 TX load rule:
  - If the buffer is full, the shift register takes the buffer and the buffer empties.
  - Otherwise the shift register takes IDLE_BYTE and tx_underrun pulses for 1 cycle.
REQ-025 In ACTIVE, on a detected SCLK fall:
  - If counter != 0: shift the TX shift register left by 1.
  - If counter == 0 (byte boundary): perform a TX load per REQ-024.
  - Either way, spi_miso = new shift[7].
REQ-026 Handshake: the buffer is written when tx_valid && tx_ready at a clk_clk edge. tx_ready=1 iff the buffer is empty. tx_data is ignored when tx_ready=0.
REQ-027 Write and load in the same cycle with an empty buffer: the load takes IDLE_BYTE (underrun pulses), and the written byte stays buffered for the next load.
REQ-028 SS_n rise mid-byte (counter != 0):
  - The partial RX byte is discarded and rx_valid does not pulse.
  - The TX byte in the shift register is lost; the buffer is untouched.
  - Counter=0; spi_miso_oe=0 in the next cycle.
REQ-029 SCLK and MOSI edges are ignored in IDLE. spi_miso is held 0 in IDLE.
REQ-030 rx_valid has no backpressure; a byte not consumed before the next rx_valid is overwritten.

Reset
REQ-031 While reset_reset_n=0, all outputs take their reset values asynchronously: state=IDLE, spi_miso=0, spi_miso_oe=0, tx_ready=1, rx_data=8'h00, rx_valid=0, tx_underrun=0, busy=0.
REQ-032 During reset the counter, shift registers and buffer clear, and synchronizer flops reset to their idle levels (sclk=0, mosi=0, ss_n=1).
REQ-033 Reset asserted mid-transfer aborts with no rx_valid. After release, the block waits for a fresh SS_n fall.

Verification
REQ-034 Write 8'hA5, then the master sends 8'h3C with SCLK phases of 6 clocks: MISO bits read 1,0,1,0,0,1,0,1; rx_data=8'h3C; one rx_valid pulse at the latency in REQ-023.
REQ-035 Two-byte burst under one SS_n, buffer written 8'h01 then 8'h02 (second write while tx_ready): master receives 01,02; two rx_valid pulses; no tx_underrun.
REQ-036 No TX write before SS_n fall: master receives 8'hFF; tx_underrun pulses exactly once at the SS_n fall detection.
REQ-037 SS_n deasserted after 5 SCLK rises: no rx_valid; spi_miso_oe=0; busy=0. The next full 8'h96 transfer yields rx_data=8'h96.
REQ-038 reset_reset_n pulsed low after bit 3: outputs match REQ-031 immediately. A subsequent full transfer of 8'h5A returns rx_data=8'h5A and MISO=IDLE_BYTE.
